// File: rtl/ram_banked_clr_pkg.sv
// Shared types for the banked data memory with hardware clear sweep.
package ram_banked_clr_pkg;

  // Sequencer state: idle (normal access) or sweeping zeros through all banks.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_banked_clr_bank.sv
// Single memory bank: asynchronous read, synchronous write, no reset on contents.
module ram_bank #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_banked_clr.sv
// Banked data memory: combinational read, synchronous write, and a clear
// sequencer that zeroes every word on reset or on request (busy while sweeping).
module ram_banked_clr
  import ram_banked_clr_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned BANK_BITS      = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic                  clear,
  output logic [WIDTH-1:0]      out,
  output logic                  busy
);

  localparam int unsigned LOCAL_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int unsigned NBANKS     = 1 << BANK_BITS;

  ram_state_e            state_q, state_d;
  logic [LOCAL_BITS-1:0] cnt_q, cnt_d;

  logic [LOCAL_BITS-1:0] local_addr;
  logic [NBANKS-1:0]     bank_sel;
  logic [WIDTH-1:0]      rd_mux;
  logic [WIDTH-1:0]      rdata [NBANKS];

  logic [LOCAL_BITS-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [NBANKS-1:0]     we;

  assign local_addr = address[LOCAL_BITS-1:0];
  assign busy       = (state_q == ST_CLEAR);

  // With no bank bits there is a single always-selected bank; the bank-select
  // slice only exists in the multi-bank branch so nothing has zero width.
  if (BANK_BITS == 0) begin : g_single
    assign bank_sel = 1'b1;
    assign rd_mux   = rdata[0];
  end else begin : g_multi
    logic [BANK_BITS-1:0] bank_idx;
    assign bank_idx = address[ADDR_WIDTH-1 -: BANK_BITS];

    // One-hot decode of the bank-select address MSBs.
    always_comb begin
      bank_sel           = '0;
      bank_sel[bank_idx] = 1'b1;
    end

    assign rd_mux = rdata[bank_idx];
  end

  // Shared write port: the sweep drives every bank, otherwise only the
  // addressed bank sees load; a clear request in the same cycle drops the load.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      waddr = cnt_q;
      wdata = '0;
      we    = '1;
    end else begin
      waddr = local_addr;
      wdata = in;
      we    = (load && !clear) ? bank_sel : '0;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ram_bank #(
      .WIDTH      (WIDTH),
      .DEPTH_BITS (LOCAL_BITS)
    ) u_bank (
      .clk   (clk),
      .we    (we[b]),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (local_addr),
      .rdata (rdata[b])
    );
  end

  assign out = busy ? '0 : rd_mux;

  // Next state: start a sweep on clear, leave it after the all-ones word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + LOCAL_BITS'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset restarts the sweep from word 0 when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_banked_clr.sv
// Directed scoreboard bench for ram_banked_clr: default config, a no-clear-on-reset
// config and a single-bank config.
module tb_ram_banked_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: defaults (WIDTH=16, ADDR_WIDTH=9, BANK_BITS=1, CLEAR_ON_RESET=1)
  logic        reset_a, load_a, clear_a, busy_a;
  logic [8:0]  addr_a;
  logic [15:0] in_a, out_a;
  // B: CLEAR_ON_RESET=0
  logic        reset_b, load_b, clear_b, busy_b;
  logic [8:0]  addr_b;
  logic [15:0] in_b, out_b;
  // C: single bank, WIDTH=8, ADDR_WIDTH=4
  logic        reset_c, load_c, clear_c, busy_c;
  logic [3:0]  addr_c;
  logic [7:0]  in_c, out_c;

  ram_banked_clr dut_a (
    .clk(clk), .reset(reset_a), .address(addr_a), .in(in_a), .load(load_a),
    .clear(clear_a), .out(out_a), .busy(busy_a)
  );

  ram_banked_clr #(.CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .address(addr_b), .in(in_b), .load(load_b),
    .clear(clear_b), .out(out_b), .busy(busy_b)
  );

  ram_banked_clr #(.WIDTH(8), .ADDR_WIDTH(4), .BANK_BITS(0)) dut_c (
    .clk(clk), .reset(reset_c), .address(addr_c), .in(in_c), .load(load_c),
    .clear(clear_c), .out(out_c), .busy(busy_c)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic chk_busy(input string tag, input int sel, input logic exp);
    push(tag, {15'd0, exp});
    pop_check({15'd0, busy_of(sel)});
  endtask

  task automatic rd(input string tag, input int sel, input int unsigned addr,
                    input logic [15:0] exp);
    logic [15:0] obs;
    case (sel)
      0:       addr_a = 9'(addr);
      1:       addr_b = 9'(addr);
      default: addr_c = 4'(addr);
    endcase
    push(tag, exp);
    #1;
    case (sel)
      0:       obs = out_a;
      1:       obs = out_b;
      default: obs = {8'h00, out_c};
    endcase
    pop_check(obs);
  endtask

  task automatic wr(input int sel, input int unsigned addr, input logic [15:0] data);
    case (sel)
      0:       begin addr_a = 9'(addr); in_a = data;     load_a = 1'b1; end
      1:       begin addr_b = 9'(addr); in_b = data;     load_b = 1'b1; end
      default: begin addr_c = 4'(addr); in_c = data[7:0]; load_c = 1'b1; end
    endcase
    tick();
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
  endtask

  // Counts edges until busy falls (bounded); n0 = edges already spent in the sweep.
  task automatic sweep_len(input string tag, input int sel, input int unsigned n0,
                           input int unsigned exp_n);
    int unsigned n = n0;
    while (busy_of(sel) === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    push(tag, 16'(exp_n));
    pop_check(16'(n));
  endtask

  initial begin
    reset_a = 1'b1; load_a = 1'b0; clear_a = 1'b0; addr_a = '0; in_a = '0;
    reset_b = 1'b1; load_b = 1'b0; clear_b = 1'b0; addr_b = '0; in_b = '0;
    reset_c = 1'b1; load_c = 1'b0; clear_c = 1'b0; addr_c = '0; in_c = '0;

    // Reset starts a full sweep
    tick();
    reset_a = 1'b0;
    chk_busy("a_reset_busy", 0, 1'b1);
    rd("a_reset_out0", 0, 0, 16'h0000);
    sweep_len("a_reset_sweep", 0, 0, 256);
    chk_busy("a_idle_after_sweep", 0, 1'b0);
    rd("a_rd0", 0, 0, 16'h0000);
    rd("a_rd255", 0, 255, 16'h0000);
    rd("a_rd256", 0, 256, 16'h0000);
    rd("a_rd511", 0, 511, 16'h0000);

    // Bank isolation
    wr(0, 5, 16'h1234);
    wr(0, 261, 16'hBEEF);
    rd("a_iso5", 0, 5, 16'h1234);
    rd("a_iso261", 0, 261, 16'hBEEF);
    rd("a_iso256", 0, 256, 16'h0000);

    // Load and clear while busy are both ignored; out forced to 0
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk_busy("a_clr_busy", 0, 1'b1);
    rd("a_busy_out_forced", 0, 261, 16'h0000);
    addr_a = 9'd10; in_a = 16'hAAAA; load_a = 1'b1; clear_a = 1'b1;
    repeat (5) tick();
    load_a = 1'b0; clear_a = 1'b0;
    sweep_len("a_clr_sweep_no_restart", 0, 5, 256);
    rd("a_busy_load_dropped", 0, 10, 16'h0000);
    rd("a_clr_wiped5", 0, 5, 16'h0000);
    rd("a_clr_wiped261", 0, 261, 16'h0000);

    // Clear + load collision: load dropped, sweep runs
    wr(0, 7, 16'h5555);
    rd("a_pre_coll7", 0, 7, 16'h5555);
    addr_a = 9'd7; in_a = 16'h7777; load_a = 1'b1; clear_a = 1'b1;
    tick();
    load_a = 1'b0; clear_a = 1'b0;
    chk_busy("a_coll_busy", 0, 1'b1);
    sweep_len("a_coll_sweep", 0, 0, 256);
    rd("a_coll7", 0, 7, 16'h0000);

    // Reset mid-sweep restarts the sweep
    wr(0, 400, 16'h1111);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    repeat (100) tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk_busy("a_midrst_busy", 0, 1'b1);
    sweep_len("a_midrst_sweep", 0, 0, 256);
    rd("a_midrst0", 0, 0, 16'h0000);
    rd("a_midrst400", 0, 400, 16'h0000);
    rd("a_midrst511", 0, 511, 16'h0000);

    // CLEAR_ON_RESET=0: reset leaves contents intact
    reset_b = 1'b0;
    chk_busy("b_reset_idle", 1, 1'b0);
    wr(1, 300, 16'h00FF);
    rd("b_wr300", 1, 300, 16'h00FF);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    chk_busy("b_rst_pulse_idle", 1, 1'b0);
    rd("b_keep300", 1, 300, 16'h00FF);
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    sweep_len("b_clr_sweep", 1, 0, 256);
    rd("b_clr300", 1, 300, 16'h0000);

    // Single bank: sweep covers the whole 16-word space
    reset_c = 1'b0;
    chk_busy("c_reset_busy", 2, 1'b1);
    sweep_len("c_sweep", 2, 0, 16);
    wr(2, 9, 16'h005A);
    rd("c_rd9", 2, 9, 16'h005A);
    rd("c_rd3", 2, 3, 16'h0000);
    rd("c_rd15", 2, 15, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
